// File: rtl/demux_1_9_loader.sv
// Serial-to-parallel loader: steers a valid/ready word stream into nine
// holding registers and presents each completed group with its own handshake.
module demux_1_9_loader #(
    parameter int DATA_W  = 16,
    parameter int NUM_OUT = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    output logic [DATA_W-1:0] out_1,
    output logic [DATA_W-1:0] out_2,
    output logic [DATA_W-1:0] out_3,
    output logic [DATA_W-1:0] out_4,
    output logic [DATA_W-1:0] out_5,
    output logic [DATA_W-1:0] out_6,
    output logic [DATA_W-1:0] out_7,
    output logic [DATA_W-1:0] out_8,
    output logic [DATA_W-1:0] out_9,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        select
);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [3:0]        select_q;
    logic [3:0]        select_d;
    logic              wr_en;
    logic [DATA_W-1:0] slot_q [NUM_OUT];

    always_comb begin
        state_d  = state_q;
        select_d = select_q;
        wr_en    = 1'b0;
        unique case (state_q)
            FILL: begin
                // flush wins over a same-cycle accept; that word is dropped
                if (flush) begin
                    select_d = 4'd0;
                end else if (in_valid) begin
                    wr_en = 1'b1;
                    if (select_q == 4'd8) begin
                        select_d = 4'd0;
                        state_d  = FULL;
                    end else begin
                        select_d = select_q + 4'd1;
                    end
                end
            end
            FULL: begin
                if (out_ready) begin
                    state_d = FILL;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FILL;
            select_q <= 4'd0;
            for (int i = 0; i < NUM_OUT; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            select_q <= select_d;
            for (int i = 0; i < NUM_OUT; i++) begin
                if (wr_en && select_q == 4'(i)) begin
                    slot_q[i] <= in_data;
                end
            end
        end
    end

    assign in_ready  = (state_q == FILL) && !rst;
    assign out_valid = (state_q == FULL);
    assign select    = select_q;

    assign out_1 = slot_q[0];
    assign out_2 = slot_q[1];
    assign out_3 = slot_q[2];
    assign out_4 = slot_q[3];
    assign out_5 = slot_q[4];
    assign out_6 = slot_q[5];
    assign out_7 = slot_q[6];
    assign out_8 = slot_q[7];
    assign out_9 = slot_q[8];

endmodule

// File: doc/demux_1_9_loader.md
Name: demux_1_9_loader

Overview:
- Reverse companion of the 9:1 output mux.
- Accepts a serial stream of 16-bit fixed-point words over a valid/ready handshake and steers each word into one of 9 parallel holding registers, in order.
- Presents the completed 9-word group as a parallel bundle with its own valid/ready handshake.
- Used to assemble 3x3 weight/activation windows for the autoencoder datapath from a single-word bus.

Parameters:
- DATA_W, 16, word width of input stream and each parallel output.
- NUM_OUT, 9, words per group; fixed at 9 in this revision, with a 4-bit index.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- in_data  input  16  incoming word.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block can accept a word this cycle.
- flush  input  1  discards a partially filled group.
- out_1 .. out_9  output  16 each  parallel group words; out_1 holds the first-accepted word.
- out_valid  output  1  the group is complete and stable.
- out_ready  input  1  consumer takes the group.
- select  output  4  index of the next slot to be written, 0..8.

Behaviour:
- Reset: out_1..out_9 = 16'h0000, select = 0, out_valid = 0, state = FILL. in_ready is forced 0 while rst = 1.
- State FILL:
  - in_ready = 1, out_valid = 0.
  - Acceptance happens when in_valid & in_ready at a rising edge. On acceptance, out_{select+1} <= in_data and no other slot changes.
  - When select < 8 on acceptance: select <= select + 1.
  - When select == 8 on acceptance: select <= 0 and state <= FULL. out_valid = 1 on the next cycle, one cycle after the 9th accept.
- State FULL:
  - in_ready = 0, out_valid = 1. out_1..out_9 hold stable; in_data and in_valid are ignored.
  - When out_ready = 1, state <= FILL. in_ready = 1 and out_valid = 0 on the following cycle.
  - No same-cycle pass-through: minimum group period = 9 accept cycles + 1 FULL cycle.
- flush:
  - In FILL: select <= 0. Already-written slots keep their old data. flush has priority over a simultaneous accept; that word is dropped and select still goes to 0.
  - In FULL: no effect. A completed group is never discarded.
- Slot contents after FULL -> FILL: slots keep the previous group's values until overwritten. Consumers must sample only while out_valid = 1.
- select never takes values 9..15. Comparisons use select == 4'd8.
- rst asserted mid-group or in FULL: all state returns to reset values on the next edge, regardless of in_valid, flush or out_ready.
- No arithmetic on data; words pass through bit-exact. Signed fixed-point interpretation is the consumer's concern.
- Outputs are registered except in_ready and out_valid, which decode directly from the state register (in_ready also gated by rst).

Test Plan:
- Reset then feed 1..9 (16'h0001..16'h0009) back-to-back with out_ready = 0 -> out_valid rises the cycle after the 9th accept; out_1 = 0001 .. out_9 = 0009; in_ready = 0 and outputs stable for 20 idle cycles; pulse out_ready -> next cycle out_valid = 0, in_ready = 1, select = 0.
- Feed with in_valid toggling every other cycle (values 16'hA000 + k) -> only valid cycles advance select; the group completes after 9 valid beats with the correct ordering.
- Feed 16'h1111, 2222, 3333, then assert flush together with in_valid and 16'h4444; then feed 9 words 16'hB001..B009 -> 4444 is dropped; final group is out_1 = B001 .. out_9 = B009.
- In FULL, drive in_valid = 1 with 16'hDEAD and pulse flush -> out_1..out_9 unchanged, out_valid stays 1, select = 0.
- Assert rst after 5 accepts and again while in FULL -> next cycle all out_n = 0, select = 0, out_valid = 0; in_ready = 1 once rst falls.
- Two consecutive groups with out_ready tied to 1 -> out_valid high exactly 1 cycle per group; group period = 10 cycles; second group's values replace the first's slot by slot.
